// File: rtl/pid_chn_scheduler.sv
// pid_chn_scheduler: round-robin sequencer sharing one 3p3z PID core among NUM_CHN channels,
// one request in flight at a time over a valid/ready handshake with result timeout.
module pid_chn_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CHN = 4,
  parameter int TIMEOUT_CYC = 255,
  localparam int CHN_WIDTH = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHN-1:0]            rpm_valid_i,
  input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
  input  logic                          ref_we_i,
  input  logic [CHN_WIDTH-1:0]          ref_chn_i,
  input  logic [DATA_WIDTH-1:0]         ref_data_i,
  input  logic                          clr_flags_i,
  output logic                          data_valid_o,
  output logic [CHN_WIDTH-1:0]          data_chn_o,
  output logic [DATA_WIDTH-1:0]         data_fdb_o,
  output logic [DATA_WIDTH-1:0]         data_ref_o,
  input  logic                          tready_i,
  input  logic                          u_valid_i,
  input  logic [CHN_WIDTH-1:0]          u_chn_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NUM_CHN-1:0]            overrun_o,
  output logic                          timeout_o
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_U} state_t;
  state_t state;
  logic [NUM_CHN-1:0] pend, take_vec;
  logic [DATA_WIDTH-1:0] sample [NUM_CHN];
  logic [DATA_WIDTH-1:0] ref_r [NUM_CHN];
  logic [CHN_WIDTH-1:0] last_grant, gnt;
  logic [TW-1:0] cnt;
  logic any, take, hit, expire;
  // descending scan so the last hit written is the first pending channel after last_grant
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = NUM_CHN; i >= 1; i--)
      if (pend[(int'(last_grant) + i) % NUM_CHN]) begin
        gnt = CHN_WIDTH'((int'(last_grant) + i) % NUM_CHN);
        any = 1'b1;
      end
  end
  assign take = (state == IDLE) && any;
  assign take_vec = take ? (NUM_CHN'(1) << gnt) : '0;
  assign hit = (state == WAIT_U) && u_valid_i && (u_chn_i == data_chn_o);
  assign expire = (state == WAIT_U) && !hit && (cnt == TW'(1));
  assign busy_o = (state != IDLE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pend <= '0;
      last_grant <= CHN_WIDTH'(NUM_CHN - 1);
      cnt <= '0;
      data_valid_o <= 1'b0;
      data_chn_o <= '0;
      data_fdb_o <= '0;
      data_ref_o <= '0;
      done_o <= 1'b0;
      overrun_o <= '0;
      timeout_o <= 1'b0;
      for (int k = 0; k < NUM_CHN; k++) begin
        sample[k] <= '0;
        ref_r[k] <= '0;
      end
    end else begin
      // a fresh sample on the granted channel re-arms pend without counting as overrun
      pend <= (pend & ~take_vec) | rpm_valid_i;
      overrun_o <= (clr_flags_i ? '0 : overrun_o) | (rpm_valid_i & pend & ~take_vec);
      timeout_o <= (timeout_o & ~clr_flags_i) | expire;
      done_o <= hit;
      for (int k = 0; k < NUM_CHN; k++) begin
        if (rpm_valid_i[k]) sample[k] <= rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        if (ref_we_i && ref_chn_i == CHN_WIDTH'(k)) ref_r[k] <= ref_data_i;
      end
      case (state)
        IDLE: if (any) begin
          data_chn_o <= gnt;
          data_fdb_o <= sample[gnt];
          data_ref_o <= ref_r[gnt];
          last_grant <= gnt;
          data_valid_o <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (tready_i) begin
          data_valid_o <= 1'b0;
          cnt <= TW'(TIMEOUT_CYC);
          state <= WAIT_U;
        end
        WAIT_U: begin
          cnt <= cnt - 1'b1;
          if (hit || expire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pid_chn_scheduler.sv
// tb_pid_chn_scheduler: directed stimulus with a request scoreboard checked by a negedge monitor
// that also models the PID core's delayed result strobe.
module tb_pid_chn_scheduler;
  logic clk = 0, rst = 1;
  logic [3:0] rpm_valid_i = '0;
  logic [63:0] rpm_data_i = '0;
  logic ref_we_i = 0;
  logic [1:0] ref_chn_i = '0;
  logic [15:0] ref_data_i = '0;
  logic clr_flags_i = 0, tready_i = 0;
  logic data_valid_o, busy_o, done_o, timeout_o, u_valid_i;
  logic [1:0] data_chn_o, u_chn_i;
  logic [15:0] data_fdb_o, data_ref_o;
  logic [3:0] overrun_o;
  logic core_v = 0, man_v = 0, auto_resp = 1;
  logic [1:0] core_chn = '0, man_chn = '0;
  int resp_cnt = 0, resp_delay = 3, done_cnt = 0, total = 0, bad = 0;
  logic [33:0] exp_q[$];
  assign u_valid_i = core_v | man_v;
  assign u_chn_i = core_v ? core_chn : man_chn;

  pid_chn_scheduler #(.DATA_WIDTH(16), .NUM_CHN(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .rpm_valid_i(rpm_valid_i), .rpm_data_i(rpm_data_i),
    .ref_we_i(ref_we_i), .ref_chn_i(ref_chn_i), .ref_data_i(ref_data_i),
    .clr_flags_i(clr_flags_i), .data_valid_o(data_valid_o), .data_chn_o(data_chn_o),
    .data_fdb_o(data_fdb_o), .data_ref_o(data_ref_o), .tready_i(tready_i),
    .u_valid_i(u_valid_i), .u_chn_i(u_chn_i), .busy_o(busy_o), .done_o(done_o),
    .overrun_o(overrun_o), .timeout_o(timeout_o));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic void push(input logic [1:0] c, input logic [15:0] f, input logic [15:0] r);
    exp_q.push_back({c, f, r});
  endfunction

  // monitor + core model
  always @(negedge clk) begin
    core_v = 0;
    if (done_o) done_cnt++;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) core_v = 1;
    end
    if (data_valid_o && tready_i) begin
      if (exp_q.size() == 0) chk("unexpected_req", {data_chn_o, data_fdb_o, data_ref_o}, 0);
      else chk("req", {data_chn_o, data_fdb_o, data_ref_o}, exp_q.pop_front());
      if (auto_resp) begin
        resp_cnt = resp_delay;
        core_chn = data_chn_o;
      end
    end
  end

  task automatic strobe(input logic [3:0] m, input logic [63:0] d);
    rpm_valid_i = m;
    rpm_data_i = d;
    @(negedge clk);
    rpm_valid_i = '0;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    @(negedge clk);
    while (!data_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, data_valid_o, 1);
  endtask

  task automatic wait_done(input int n, input string nm);
    int s = done_cnt;
    int k = 0;
    while (done_cnt < s + n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(nm, done_cnt - s, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int d0;
    #3;
    chk("reset_outs", {data_valid_o, busy_o, done_o, overrun_o, timeout_o}, 0);
    @(negedge clk);
    rst = 0;
    // basic round robin
    tready_i = 1;
    for (int k = 0; k < 4; k++) begin
      ref_we_i = 1;
      ref_chn_i = 2'(k);
      ref_data_i = 16'(100 * (k + 1));
      @(negedge clk);
    end
    ref_we_i = 0;
    push(0, 10, 100); push(1, 20, 200); push(2, 30, 300); push(3, 40, 400);
    strobe(4'b1111, {16'd40, 16'd30, 16'd20, 16'd10});
    wait_done(4, "rr_done");
    chk("rr_flags", {overrun_o, timeout_o}, 0);
    // backpressure hold on ch1
    tready_i = 0;
    push(1, 20, 200); push(1, 55, 250);
    strobe(4'b0010, {32'd0, 16'd20, 16'd0});
    wait_valid("hold_valid");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_payload", {data_valid_o, data_chn_o, data_fdb_o, data_ref_o}, {1'b1, 2'd1, 16'd20, 16'd200});
      rpm_valid_i = '0;
      ref_we_i = 0;
      if (i == 2) begin
        rpm_valid_i = 4'b0010;
        rpm_data_i = {32'd0, 16'd55, 16'd0};
        ref_we_i = 1;
        ref_chn_i = 1;
        ref_data_i = 250;
      end
    end
    tready_i = 1;
    wait_done(2, "hold_done");
    chk("hold_no_overrun", overrun_o, 0);
    // overrun on ch2 while ch0 in flight
    resp_delay = 6;
    push(0, 11, 100); push(2, 9, 300);
    strobe(4'b0001, 64'd11);
    wait_valid("ovr_valid");
    @(negedge clk);
    strobe(4'b0100, {16'd0, 16'd7, 32'd0});
    strobe(4'b0100, {16'd0, 16'd9, 32'd0});
    chk("ovr_set", overrun_o, 4'b0100);
    wait_done(2, "ovr_done");
    chk("ovr_sticky", overrun_o, 4'b0100);
    clr_flags_i = 1;
    @(negedge clk);
    clr_flags_i = 0;
    chk("ovr_clr", overrun_o, 0);
    resp_delay = 3;
    // timeout on ch3, then pending ch0 served
    auto_resp = 0;
    push(3, 33, 400); push(0, 44, 100);
    strobe(4'b1000, {16'd33, 48'd0});
    wait_valid("to_valid");
    d0 = done_cnt;
    @(negedge clk);
    strobe(4'b0001, 64'd44);
    repeat (6) @(negedge clk);
    chk("to_early", timeout_o, 0);
    @(negedge clk);
    chk("to_set", {timeout_o, busy_o}, 2'b10);
    chk("to_no_done", done_cnt - d0, 0);
    auto_resp = 1;
    wait_done(1, "to_next_done");
    clr_flags_i = 1;
    @(negedge clk);
    clr_flags_i = 0;
    chk("to_clr", timeout_o, 0);
    // wrong-channel result ignored
    auto_resp = 0;
    push(1, 66, 250);
    strobe(4'b0010, {32'd0, 16'd66, 16'd0});
    wait_valid("wc_valid");
    d0 = done_cnt;
    @(negedge clk);
    man_v = 1;
    man_chn = 2;
    @(negedge clk);
    man_v = 0;
    @(negedge clk);
    chk("wc_ignored", {done_o, busy_o, 8'(done_cnt - d0)}, {1'b0, 1'b1, 8'd0});
    man_v = 1;
    man_chn = 1;
    @(negedge clk);
    man_v = 0;
    chk("wc_match", {done_o, busy_o}, 2'b10);
    auto_resp = 1;
    // async reset during ISSUE
    tready_i = 0;
    strobe(4'b1100, {16'd3, 16'd5, 32'd0});
    wait_valid("rst_valid");
    strobe(4'b1000, {16'd8, 48'd0});
    chk("rst_pre_ovr", overrun_o, 4'b1000);
    rst = 1;
    #1;
    chk("rst_async", {data_valid_o, busy_o, done_o, overrun_o, timeout_o}, 0);
    @(negedge clk);
    rst = 0;
    tready_i = 1;
    push(0, 1, 0); push(3, 2, 0);
    strobe(4'b1001, {16'd2, 32'd0, 16'd1});
    wait_done(2, "rst_done");
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
